// File: rtl/lzd_seq.sv
// -----------------------------------------------------------------------------
// lzd_seq
//   Sequential leading-zero / leading-one detector with valid/ready handshakes.
//   The operand is scanned MSB-first, CHUNK bits per cycle, stopping at the
//   first chunk that holds a non-matching bit.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active-high
//   i_vld          request valid
//   i_x            operand (W bits)
//   i_detect_zero  1: count leading zeros, 0: count leading ones
//   o_rdy          request ready (IDLE and not in reset)
//   o_vld          result valid, held until i_rdy
//   o_cnt          number of leading matching bits, 0..W
//   o_onehot       one-hot position of the first non-matching bit, 0 if none
//   o_all          whole operand matched (o_cnt == W)
//   i_rdy          result ready
// -----------------------------------------------------------------------------
module lzd_seq #(
    parameter int W     = 64,
    parameter int CHUNK = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_vld,
    input  logic [W-1:0]               i_x,
    input  logic                       i_detect_zero,
    output logic                       o_rdy,
    output logic                       o_vld,
    output logic [$clog2(W+1)-1:0]     o_cnt,
    output logic [W-1:0]               o_onehot,
    output logic                       o_all,
    input  logic                       i_rdy
);

    localparam int CNT_W = $clog2(W+1);

    if (W < 2 || CHUNK < 1 || (W % CHUNK) != 0) begin : g_bad_param
        $error("lzd_seq: W must be >= 2 and a multiple of CHUNK");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'(W - CHUNK);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_MSB   = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CHUNK_C   = CNT_W'(CHUNK);
    localparam logic [W-1:0]     ONE       = W'(1);

    logic [1:0]       r_state;
    // Operand normalised so that the bit being searched for is always a 1.
    // It is shifted left by CHUNK per SCAN cycle, so the current chunk always
    // sits in the top CHUNK bits; r_base is the bit count already passed.
    logic [W-1:0]     r_xs;
    logic [CNT_W-1:0] r_base;

    logic             w_found;
    logic [CNT_W-1:0] w_lead;
    logic [CNT_W-1:0] w_cnt;
    logic [W-1:0]     w_onehot;

    // Priority encoder over the current (top) chunk.
    always_comb begin
        w_found = 1'b0;
        w_lead  = '0;
        for (int unsigned j = 0; j < CHUNK; j++) begin
            if (!w_found && r_xs[W-1-j]) begin
                w_found = 1'b1;
                w_lead  = CNT_W'(j);
            end
        end
    end

    assign w_cnt    = r_base + w_lead;
    assign w_onehot = ONE << (CNT_MSB - w_cnt);

    assign o_rdy = (r_state == S_IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_xs     <= '0;
            r_base   <= '0;
            o_vld    <= 1'b0;
            o_cnt    <= '0;
            o_onehot <= '0;
            o_all    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_vld) begin
                        r_xs    <= i_detect_zero ? i_x : ~i_x;
                        r_base  <= '0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_found) begin
                        o_cnt    <= w_cnt;
                        o_onehot <= w_onehot;
                        o_all    <= 1'b0;
                        o_vld    <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_base == LAST_BASE) begin
                        o_cnt    <= CNT_FULL;
                        o_onehot <= '0;
                        o_all    <= 1'b1;
                        o_vld    <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_xs    <= r_xs << CHUNK;
                        r_base  <= r_base + CHUNK_C;
                    end
                end
                S_DONE: begin
                    if (i_rdy) begin
                        o_vld   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lzd_seq.sv
// -----------------------------------------------------------------------------
// tb_lzd_seq
//   Directed and randomised checks of lzd_seq with W=16, CHUNK=4.
// -----------------------------------------------------------------------------
module tb_lzd_seq;

    localparam int W     = 16;
    localparam int CHUNK = 4;
    localparam int CNT_W = $clog2(W+1);

    logic             clk = 1'b0;
    logic             rst;
    logic             i_vld;
    logic [W-1:0]     i_x;
    logic             i_detect_zero;
    logic             o_rdy;
    logic             o_vld;
    logic [CNT_W-1:0] o_cnt;
    logic [W-1:0]     o_onehot;
    logic             o_all;
    logic             i_rdy;

    int tests = 0;
    int fails = 0;

    lzd_seq #(.W(W), .CHUNK(CHUNK)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_vld         (i_vld),
        .i_x           (i_x),
        .i_detect_zero (i_detect_zero),
        .o_rdy         (o_rdy),
        .o_vld         (o_vld),
        .o_cnt         (o_cnt),
        .o_onehot      (o_onehot),
        .o_all         (o_all),
        .i_rdy         (i_rdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Invariants on every cycle where a result is presented.
    always @(negedge clk) begin
        if (rst === 1'b0 && o_vld === 1'b1) begin
            tests++;
            assert ($countones(o_onehot) <= 1) else begin
                fails++;
                $error("FAIL inv_popcount observed=%0h expected=popcount<=1", o_onehot);
            end
            tests++;
            assert (o_all === (o_onehot == '0)) else begin
                fails++;
                $error("FAIL inv_all observed=%0b expected=%0b", o_all, (o_onehot == '0));
            end
            if (o_all === 1'b0) begin
                tests++;
                assert (o_cnt === CNT_W'(W - 1 - $clog2(o_onehot))) else begin
                    fails++;
                    $error("FAIL inv_cnt observed=%0d expected=%0d", o_cnt, W - 1 - $clog2(o_onehot));
                end
            end
        end
    end

    // Reference model: leading matching bits of x.
    function automatic logic [CNT_W-1:0] ref_cnt(input logic [W-1:0] x, input logic dz);
        logic [W-1:0] xs;
        xs = dz ? x : ~x;
        for (int i = W - 1; i >= 0; i--) begin
            if (xs[i]) return CNT_W'(W - 1 - i);
        end
        return CNT_W'(W);
    endfunction

    // Waits for o_rdy, issues one request, and returns the number of edges
    // after the accept edge until o_vld is seen (bounded).
    task automatic issue(input logic [W-1:0] x, input logic dz, output int n);
        int k;
        k = 0;
        while (o_rdy !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        chk("rdy_before_issue", 64'(o_rdy), 64'd1);
        i_vld = 1'b1;
        i_x = x;
        i_detect_zero = dz;
        step();
        i_vld = 1'b0;
        i_x = ~x;
        i_detect_zero = ~dz;
        n = 0;
        while (o_vld !== 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic dz,
                          input logic [CNT_W-1:0] e_cnt, input logic [W-1:0] e_oh,
                          input logic e_all, input int e_lat);
        int n;
        issue(x, dz, n);
        chk({tag, "_lat"}, 64'(n + 1), 64'(e_lat));
        chk({tag, "_cnt"}, 64'(o_cnt), 64'(e_cnt));
        chk({tag, "_oh"}, 64'(o_onehot), 64'(e_oh));
        chk({tag, "_all"}, 64'(o_all), 64'(e_all));
        chk({tag, "_rdy_busy"}, 64'(o_rdy), 64'd0);
        step();
        chk({tag, "_vld_drop"}, 64'(o_vld), 64'd0);
        chk({tag, "_rdy_back"}, 64'(o_rdy), 64'd1);
        chk({tag, "_cnt_hold"}, 64'(o_cnt), 64'(e_cnt));
    endtask

    initial begin
        int n;
        logic [W-1:0]     rx;
        logic             rdz;
        logic [CNT_W-1:0] ecnt;
        logic             eall;
        logic [W-1:0]     eoh;

        rst = 1'b1;
        i_vld = 1'b0;
        i_x = '0;
        i_detect_zero = 1'b1;
        i_rdy = 1'b1;
        step();
        step();
        chk("reset_rdy", 64'(o_rdy), 64'd0);
        chk("reset_vld", 64'(o_vld), 64'd0);
        chk("reset_cnt", 64'(o_cnt), 64'd0);
        chk("reset_oh", 64'(o_onehot), 64'd0);
        chk("reset_all", 64'(o_all), 64'd0);
        rst = 1'b0;
        #1;
        chk("rdy_after_reset", 64'(o_rdy), 64'd1);

        // Directed cases
        run_op("c1_msb", 16'h8000, 1'b1, 5'd0, 16'h8000, 1'b0, 2);
        run_op("c2_lsb", 16'h0001, 1'b1, 5'd15, 16'h0001, 1'b0, 5);
        run_op("c3_zero", 16'h0000, 1'b1, 5'd16, 16'h0000, 1'b1, 5);
        run_op("c3_ones", 16'hFFFF, 1'b0, 5'd16, 16'h0000, 1'b1, 5);
        run_op("c4_lo", 16'hFF0F, 1'b0, 5'd8, 16'h0080, 1'b0, 4);
        run_op("c_chunk1", 16'h0400, 1'b1, 5'd5, 16'h0400, 1'b0, 3);

        // Backpressure: result held, request side ignored
        i_rdy = 1'b0;
        issue(16'h8000, 1'b1, n);
        chk("c5_lat", 64'(n + 1), 64'd2);
        for (int c = 0; c < 10; c++) begin
            i_vld = c[0];
            i_x = 16'(c * 16'h1357);
            i_detect_zero = c[1];
            step();
            chk("c5_vld_hold", 64'(o_vld), 64'd1);
            chk("c5_cnt_hold", 64'(o_cnt), 64'd0);
            chk("c5_oh_hold", 64'(o_onehot), 64'h8000);
            chk("c5_all_hold", 64'(o_all), 64'd0);
            chk("c5_rdy_low", 64'(o_rdy), 64'd0);
        end
        i_vld = 1'b0;
        i_rdy = 1'b1;
        step();
        chk("c5_vld_drop", 64'(o_vld), 64'd0);
        chk("c5_rdy_back", 64'(o_rdy), 64'd1);

        // Reset in the middle of a scan
        i_vld = 1'b1;
        i_x = 16'h0001;
        i_detect_zero = 1'b1;
        step();             // accepted; now in cycle t+1
        i_vld = 1'b0;
        step();             // cycle t+2
        rst = 1'b1;
        #1;
        chk("c6_rdy_in_rst", 64'(o_rdy), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("c6_rdy_after", 64'(o_rdy), 64'd1);
        chk("c6_vld_after", 64'(o_vld), 64'd0);
        chk("c6_cnt_reset", 64'(o_cnt), 64'd0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (o_vld !== 1'b0) n++;
        end
        chk("c6_no_vld", 64'(n), 64'd0);
        run_op("c6_next", 16'h0030, 1'b1, 5'd10, 16'h0020, 1'b0, 4);

        // Randomised operands against the reference model
        for (int r = 0; r < 40; r++) begin
            rx = 16'($urandom) >> $urandom_range(0, 16);
            rdz = 1'($urandom_range(0, 1));
            if (!rdz) rx = ~rx;
            ecnt = ref_cnt(rx, rdz);
            eall = (ecnt == CNT_W'(W));
            eoh  = eall ? '0 : (16'h0001 << (W - 1 - int'(ecnt)));
            run_op("rand", rx, rdz, ecnt, eoh, eall,
                   eall ? (W / CHUNK) + 1 : (int'(ecnt) / CHUNK) + 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
